// File: rtl/smp_control_unit.sv
// rtl/smp_control_unit.sv - instruction sequencer for the Simple Microprocessor
//
// Purpose: fetches opcode/operand bytes over a req/ready memory handshake,
// decodes them and drives the ALU select code and accumulator load strobe.
// Owns PC, IR and MAR. Stops in HALT until the next reset.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   o_mem_req, o_mem_we       memory request (held until ready), write qualifier
//   o_mem_addr                memory address (PC or MAR)
//   i_mem_rdata, i_mem_ready  read data, request completion
//   i_ac_zero                 accumulator == 0 from the datapath
//   o_alu_select              ALU operation code decoded from IR
//   o_ac_load                 one-cycle AC load strobe
//   o_pc                      current program counter
//   o_halted                  high in HALT
//   o_illegal_op              one-cycle pulse on an undefined opcode

module smp_control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic [7:0] o_mem_addr,
    input  logic [7:0] i_mem_rdata,
    input  logic       i_mem_ready,
    input  logic       i_ac_zero,
    output logic [6:0] o_alu_select,
    output logic       o_ac_load,
    output logic [7:0] o_pc,
    output logic       o_halted,
    output logic       o_illegal_op
);

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_STA = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;
    localparam logic [7:0] OP_OR  = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08;
    localparam logic [7:0] OP_INC = 8'h09;
    localparam logic [7:0] OP_CLR = 8'h0A;
    localparam logic [7:0] OP_JMP = 8'h0B;
    localparam logic [7:0] OP_JZ  = 8'h0C;
    localparam logic [7:0] OP_HLT = 8'h0F;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_mar;

    logic       w_is_mem_rd;
    logic       w_is_sta;
    logic       w_is_reg;
    logic       w_is_jmp;
    logic       w_is_jz;
    logic       w_is_hlt;
    logic       w_is_nop;
    logic       w_has_operand;
    logic       w_undefined;
    logic       w_exec_mem;
    logic [6:0] w_alu_sel;

    // Opcode decode of the instruction register
    always_comb begin
        w_is_mem_rd = 1'b0;
        w_is_sta    = 1'b0;
        w_is_reg    = 1'b0;
        w_is_jmp    = 1'b0;
        w_is_jz     = 1'b0;
        w_is_hlt    = 1'b0;
        w_is_nop    = 1'b0;
        w_alu_sel   = 7'h00;
        case (r_ir)
            OP_NOP: w_is_nop = 1'b1;
            OP_LDA: begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h04; end
            OP_STA: w_is_sta = 1'b1;
            OP_ADD: begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h05; end
            OP_SUB: begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h0B; end
            OP_AND: begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h40; end
            OP_XOR: begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h50; end
            OP_OR:  begin w_is_mem_rd = 1'b1; w_alu_sel = 7'h60; end
            OP_NOT: begin w_is_reg = 1'b1; w_alu_sel = 7'h70; end
            OP_INC: begin w_is_reg = 1'b1; w_alu_sel = 7'h09; end
            OP_CLR: begin w_is_reg = 1'b1; w_alu_sel = 7'h00; end
            OP_JMP: w_is_jmp = 1'b1;
            OP_JZ:  w_is_jz  = 1'b1;
            OP_HLT: w_is_hlt = 1'b1;
            default: ;
        endcase
    end

    assign w_has_operand = w_is_mem_rd | w_is_sta | w_is_jmp | w_is_jz;
    assign w_undefined   = ~(w_has_operand | w_is_reg | w_is_hlt | w_is_nop);
    // EXEC cycles that use the memory bus (address from MAR)
    assign w_exec_mem    = (r_state == ST_EXEC) & (w_is_mem_rd | w_is_sta);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RST;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_mar   <= 8'h00;
        end else begin
            case (r_state)
                ST_RST: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_mem_ready) begin
                        r_ir    <= i_mem_rdata;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_has_operand)
                        r_state <= ST_OPERAND;
                    else if (w_is_hlt)
                        r_state <= ST_HALT;
                    else if (w_is_reg)
                        r_state <= ST_EXEC;
                    else
                        r_state <= ST_FETCH;    // NOP and undefined opcodes
                end
                ST_OPERAND: begin
                    if (i_mem_ready) begin
                        r_mar   <= i_mem_rdata;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_mem_rd || w_is_sta) begin
                        if (i_mem_ready)
                            r_state <= ST_FETCH;
                    end else begin
                        if (w_is_jmp || (w_is_jz && i_ac_zero))
                            r_pc <= r_mar;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RST;
            endcase
        end
    end

    // Moore-style bus/strobe decode; ac_load for memory ops waits on ready
    always_comb begin
        o_mem_req    = (r_state == ST_FETCH) | (r_state == ST_OPERAND) | w_exec_mem;
        o_mem_we     = w_exec_mem & w_is_sta;
        o_mem_addr   = w_exec_mem ? r_mar : r_pc;
        o_ac_load    = (r_state == ST_EXEC) & ((w_is_mem_rd & i_mem_ready) | w_is_reg);
        o_halted     = (r_state == ST_HALT);
        o_illegal_op = (r_state == ST_DECODE) & w_undefined;
        o_alu_select = w_alu_sel;
        o_pc         = r_pc;
    end

endmodule

// File: doc/smp_control_unit.md
# smp_control_unit

Instruction sequencer for the Simple Microprocessor: fetches opcode and operand bytes from program memory, decodes them, and drives the 7-bit ALU select code and accumulator load strobe consumed by the datapath ALU. It owns PC, IR and MAR, and talks to memory over a request/ready handshake. It stops on HLT until the next reset.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req (STA only)
- mem_addr  out  8  memory address (PC or MAR)
- mem_rdata  in  8  read data, valid when mem_ready=1 on a read
- mem_ready  in  1  completes the current request in the same cycle
- ac_zero  in  1  accumulator == 0 (datapath)
- alu_select  out  7  ALU operation code, decoded from IR
- ac_load  out  1  one-cycle strobe: AC <= ALU out (ALU bus operand = mem_rdata)
- pc  out  8  current program counter
- halted  out  1  high in HALT state
- illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: RST, FETCH, DECODE, OPERAND, EXEC, HALT. Moore outputs; mem_req, mem_we, mem_addr and ac_load are decoded from state, IR and mem_ready.
- RST: no request; goes to FETCH on the next edge.
- FETCH: mem_req=1, mem_addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE: operand opcodes go to OPERAND. HLT goes to HALT. Undefined opcodes pulse illegal_op and go to FETCH, acting as NOP. NOP goes to FETCH. All others go to EXEC.
- OPERAND: mem_req=1, mem_addr=pc. On mem_ready: MAR<=mem_rdata, pc<=pc+1, go to EXEC.
- EXEC, one of three cases, then go to FETCH:
  - Memory read ops: mem_req=1, mem_addr=MAR. The state completes on mem_ready, with ac_load=1 combinationally in that cycle.
  - STA: mem_req=1, mem_we=1, mem_addr=MAR (datapath drives AC as write data). It completes on mem_ready with no ac_load.
  - Register ops: ac_load=1 for one cycle.
- JMP/JZ complete in EXEC without a request. JMP sets pc<=MAR. JZ sets pc<=MAR if ac_zero, else pc is unchanged.
- Opcodes and their alu_select. Operand ops carry an address byte. Every opcode not listed below is undefined.
  - 0x00 NOP (no EXEC)
  - 0x01 LDA addr, 7'h04
  - 0x02 STA addr
  - 0x03 ADD addr, 7'h05
  - 0x04 SUB addr, 7'h0B
  - 0x05 AND addr, 7'h40
  - 0x06 XOR addr, 7'h50
  - 0x07 OR addr, 7'h60
  - 0x08 NOT, 7'h70
  - 0x09 INC, 7'h09
  - 0x0A CLR, 7'h00
  - 0x0B JMP addr
  - 0x0C JZ addr
  - 0x0F HLT
- alu_select is 7'h00 for any IR without an ALU code.
- PC arithmetic is 8-bit modulo: 8'hFF+1 wraps to 8'h00, and fetch continues from 0.
- HALT: halted=1, no requests, all strobes low, until rst_n asserts.

## Timing
- Reset (async, while rst_n=0): state=RST, pc=RESET_PC, IR=8'h00, MAR=8'h00. Outputs: mem_req=0, mem_we=0, mem_addr=RESET_PC, ac_load=0, halted=0, illegal_op=0, alu_select=7'h00.
- First mem_req is in the second cycle after rst_n deasserts (RST lasts one cycle).
- Cycles per instruction with mem_ready tied high:
  - NOP, illegal: 2.
  - Register ops, HLT entry: 3.
  - Memory read ops, STA, JMP, JZ: 4.
  - Each low mem_ready cycle adds one cycle.
- Handshake: while mem_req=1 and mem_ready=0, mem_addr, mem_we and state hold; ac_load stays 0.
- mem_ready is ignored when mem_req=0.
- Reset asserted mid-instruction aborts immediately to reset values. A pending request is dropped and no partial PC/IR update survives.
- ac_zero is sampled in the JZ EXEC cycle only.

## Test plan
- Reset/boot: release rst_n with ready=1 -> mem_req first high 2 cycles later with mem_addr=8'h00, and halted=0.
- Program LDA 0x20; ADD 0x21; STA 0x22; HLT with M[20]=3, M[21]=4 and ready=1:
  - ac_load pulses with alu_select 7'h04, then 7'h05.
  - Write request at addr 0x22 with mem_we=1.
  - halted=1 at cycle 16; pc=8'h07.
- Wait states: ready low 3 cycles during OPERAND of ADD -> mem_addr/state stable, no ac_load, instruction takes 7 cycles.
- JZ 0x40 with ac_zero=1 -> next fetch addr 0x40. With ac_zero=0 -> next fetch addr pc+2.
- Opcode 0x0D -> illegal_op single pulse; the next fetch is at pc+1 in 2 cycles. NOT, INC and CLR give alu_select 7'h70, 7'h09 and 7'h00, each with one ac_load.
- PC wrap and reset abort:
  - NOP at 0xFF -> next fetch at 0x00.
  - rst_n asserted mid-EXEC with ready=0 -> mem_req drops immediately and pc=RESET_PC.
